// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampled start detect, LSB-first shift,
// parity/stop checks and a valid/ready output holding one committed frame.
// Ports: clk, n_rst (async low); i_rx serial in; o_data/o_valid/i_ready
// output handshake; o_frame_err, o_parity_err flags; o_overrun pulse.
module uart_rx_deserializer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 hist;
  logic [1:0]           fill;
  logic                 fall;
  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [3:0]           tcnt;
  logic [3:0]           bcnt;
  logic                 scnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 mid;

  // History only trusts s2 once the synchroniser holds real line
  // samples, so a line low across reset release is never an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      fill <= 2'b00;
      hist <= 1'b0;
    end else begin
      s1   <= i_rx;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      hist <= fill[1] & s2;
    end
  end

  assign fall = hist & ~s2;
  assign tick = (state != S_IDLE) &&
                (pcnt == PW'(TICK_DIV - 1));
  assign mid  = tick && (tcnt == 4'd15);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      pcnt         <= '0;
      tcnt         <= '0;
      bcnt         <= '0;
      scnt         <= 1'b0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready)
        o_valid <= 1'b0;

      if (state == S_IDLE || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + PW'(1);

      if (tick)
        tcnt <= tcnt + 4'd1;

      unique case (state)
        S_IDLE: begin
          tcnt <= '0;
          bcnt <= '0;
          scnt <= 1'b0;
          perr <= 1'b0;
          ferr <= 1'b0;
          if (fall)
            state <= S_START;
        end
        S_START: begin
          if (tick && tcnt == 4'd7) begin
            tcnt  <= '0;
            state <= s2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (mid) begin
            shreg <= {s2, shreg[DATA_BITS-1:1]};
            if (bcnt == 4'(DATA_BITS - 1)) begin
              bcnt  <= '0;
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (mid) begin
            // Odd wants XOR(data,p)=1, even wants 0.
            perr  <= (^shreg) ^ s2 ^ (PARITY == 1);
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid) begin
            if (scnt == 1'(STOP_BITS - 1)) begin
              o_data       <= shreg;
              o_frame_err  <= ferr | ~s2;
              o_parity_err <= perr;
              o_valid      <= 1'b1;
              o_overrun    <= o_valid & ~i_ready;
              state        <= S_IDLE;
            end else begin
              scnt <= 1'b1;
              ferr <= ferr | ~s2;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
